// File: rtl/pipe_ctrl.sv
// Pipeline hazard/stall controller: load-use bubbles, branch flushes, memory freeze with timeout.
// Define PIPE_CTRL_PERF_EN to add saturating stall/flush/freeze performance counters.
module pipe_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_WID     = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_use,
    input  logic       branch_taken,
    input  logic       mem_busy,
    output logic       PC_Write,
    output logic       IF_ID_Write,
    output logic       IF_Flush,
    output logic       ID_Bubble,
    output logic       Pipe_Freeze,
    output logic       mem_err,
    output logic [1:0] state
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [CNT_WID-1:0] stall_cnt,
    output logic [CNT_WID-1:0] flush_cnt,
    output logic [CNT_WID-1:0] freeze_cnt
`endif
);

    localparam int TW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        FREEZE   = 2'd1,
        REDIRECT = 2'd2,
        ERR      = 2'd3
    } state_t;

    state_t        cur_state, nxt_state;
    logic          pending, pending_nxt;
    logic [TW-1:0] tmo_cnt, tmo_cnt_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_state <= RUN;
            pending   <= 1'b0;
            tmo_cnt   <= '0;
        end else begin
            cur_state <= nxt_state;
            pending   <= pending_nxt;
            tmo_cnt   <= tmo_cnt_nxt;
        end
    end

    // Entering FREEZE restarts the count at 1 so the first frozen cycle is cycle 1.
    always_comb begin
        nxt_state   = cur_state;
        pending_nxt = pending;
        tmo_cnt_nxt = tmo_cnt;
        PC_Write    = 1'b1;
        IF_ID_Write = 1'b1;
        IF_Flush    = 1'b0;
        ID_Bubble   = 1'b0;
        Pipe_Freeze = 1'b0;
        if (rst) begin
            PC_Write    = 1'b0;
            IF_ID_Write = 1'b0;
            IF_Flush    = 1'b1;
            ID_Bubble   = 1'b1;
        end else begin
            unique case (cur_state)
                RUN: begin
                    if (mem_busy) begin
                        PC_Write    = 1'b0;
                        IF_ID_Write = 1'b0;
                        Pipe_Freeze = 1'b1;
                        tmo_cnt_nxt = TW'(1);
                        nxt_state   = FREEZE;
                    end else if (branch_taken) begin
                        IF_Flush = 1'b1;
                    end else if (load_use) begin
                        PC_Write    = 1'b0;
                        IF_ID_Write = 1'b0;
                        ID_Bubble   = 1'b1;
                    end
                end
                FREEZE: begin
                    if (mem_busy) begin
                        PC_Write    = 1'b0;
                        IF_ID_Write = 1'b0;
                        Pipe_Freeze = 1'b1;
                        if (branch_taken)
                            pending_nxt = 1'b1;
                        if (tmo_cnt == TMO_MAX)
                            nxt_state = ERR;
                        else
                            tmo_cnt_nxt = tmo_cnt + 1'b1;
                    end else if (pending || branch_taken) begin
                        // Back end released now; the front end waits for the redirect cycle.
                        PC_Write    = 1'b0;
                        IF_ID_Write = 1'b0;
                        pending_nxt = 1'b1;
                        nxt_state   = REDIRECT;
                    end else begin
                        nxt_state = RUN;
                        if (load_use) begin
                            PC_Write    = 1'b0;
                            IF_ID_Write = 1'b0;
                            ID_Bubble   = 1'b1;
                        end
                    end
                end
                REDIRECT: begin
                    if (mem_busy) begin
                        PC_Write    = 1'b0;
                        IF_ID_Write = 1'b0;
                        Pipe_Freeze = 1'b1;
                        tmo_cnt_nxt = TW'(1);
                        nxt_state   = FREEZE;
                    end else begin
                        IF_Flush    = 1'b1;
                        pending_nxt = 1'b0;
                        nxt_state   = RUN;
                    end
                end
                default: begin
                    PC_Write    = 1'b0;
                    IF_ID_Write = 1'b0;
                    Pipe_Freeze = 1'b1;
                end
            endcase
        end
    end

    assign mem_err = (cur_state == ERR);
    assign state   = cur_state;

`ifdef PIPE_CTRL_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt  <= '0;
            flush_cnt  <= '0;
            freeze_cnt <= '0;
        end else begin
            if (ID_Bubble && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
            if (IF_Flush && (flush_cnt != '1))
                flush_cnt <= flush_cnt + 1'b1;
            if (Pipe_Freeze && (freeze_cnt != '1))
                freeze_cnt <= freeze_cnt + 1'b1;
        end
    end
`else
    // Keeps CNT_WID referenced when the counters are compiled out.
    logic [CNT_WID-1:0] unused_cnt_wid;
    assign unused_cnt_wid = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl: a default-timeout instance and a MEM_TIMEOUT=4 instance.
module tb_pipe_ctrl;

    logic clk;
    logic rst;
    logic load_use, branch_taken, mem_busy;

    logic       pc_w, ifid_w, if_fl, id_bub, frz, merr;
    logic [1:0] st;
    logic       t_pc_w, t_ifid_w, t_if_fl, t_id_bub, t_frz, t_merr;
    logic [1:0] t_st;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cnt, flush_cnt, freeze_cnt;
    logic [31:0] t_stall_cnt, t_flush_cnt, t_freeze_cnt;
`endif

    int errors = 0;
    int checks = 0;

    // Control vector order: {PC_Write, IF_ID_Write, IF_Flush, ID_Bubble, Pipe_Freeze}
    localparam logic [4:0] C_IDLE   = 5'b11000;
    localparam logic [4:0] C_RESET  = 5'b00110;
    localparam logic [4:0] C_BUBBLE = 5'b00010;
    localparam logic [4:0] C_FLUSH  = 5'b11100;
    localparam logic [4:0] C_FREEZE = 5'b00001;

    localparam logic [1:0] S_RUN = 2'd0, S_FREEZE = 2'd1, S_REDIR = 2'd2, S_ERR = 2'd3;

    logic [4:0] ctrl, t_ctrl;
    assign ctrl   = {pc_w, ifid_w, if_fl, id_bub, frz};
    assign t_ctrl = {t_pc_w, t_ifid_w, t_if_fl, t_id_bub, t_frz};

    pipe_ctrl dut (
        .clk(clk), .rst(rst), .load_use(load_use), .branch_taken(branch_taken), .mem_busy(mem_busy),
        .PC_Write(pc_w), .IF_ID_Write(ifid_w), .IF_Flush(if_fl), .ID_Bubble(id_bub),
        .Pipe_Freeze(frz), .mem_err(merr), .state(st)
`ifdef PIPE_CTRL_PERF_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .freeze_cnt(freeze_cnt)
`endif
    );

    pipe_ctrl #(.MEM_TIMEOUT(4)) dut_tmo (
        .clk(clk), .rst(rst), .load_use(load_use), .branch_taken(branch_taken), .mem_busy(mem_busy),
        .PC_Write(t_pc_w), .IF_ID_Write(t_ifid_w), .IF_Flush(t_if_fl), .ID_Bubble(t_id_bub),
        .Pipe_Freeze(t_frz), .mem_err(t_merr), .state(t_st)
`ifdef PIPE_CTRL_PERF_EN
        , .stall_cnt(t_stall_cnt), .flush_cnt(t_flush_cnt), .freeze_cnt(t_freeze_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 ns after the rising edge; outputs are sampled 4 ns after the edge.
    task automatic applyStimulus(input logic lu, input logic bt, input logic mb);
        @(posedge clk);
        #1;
        load_use     = lu;
        branch_taken = bt;
        mem_busy     = mb;
        #3;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
            $error("[TB] check %s did not match", tag);
        end
    endtask

    initial begin
        rst = 1'b1;
        load_use = 1'b0;
        branch_taken = 1'b0;
        mem_busy = 1'b0;
        #12;
        checkOutput("reset_ctrl", 32'(ctrl), 32'(C_RESET));
        checkOutput("reset_state", 32'(st), 32'(S_RUN));
        checkOutput("reset_mem_err", 32'(merr), 32'd0);

        @(posedge clk);
        #1 rst = 1'b0;
        #3;
        checkOutput("idle_ctrl", 32'(ctrl), 32'(C_IDLE));
        checkOutput("idle_state", 32'(st), 32'(S_RUN));

        // Single load-use bubble, then normal flow
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("lu_ctrl", 32'(ctrl), 32'(C_BUBBLE));
        checkOutput("lu_state", 32'(st), 32'(S_RUN));
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("lu_after_ctrl", 32'(ctrl), 32'(C_IDLE));

        // Branch beats load-use
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("br_lu_ctrl", 32'(ctrl), 32'(C_FLUSH));
        checkOutput("br_lu_state", 32'(st), 32'(S_RUN));
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("br_after_ctrl", 32'(ctrl), 32'(C_IDLE));

        // mem_busy beats everything
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("prio_ctrl", 32'(ctrl), 32'(C_FREEZE));
        checkOutput("prio_state", 32'(st), 32'(S_RUN));
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("release_state", 32'(st), 32'(S_FREEZE));
        checkOutput("release_ctrl", 32'(ctrl), 32'(C_IDLE));
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("release_run_state", 32'(st), 32'(S_RUN));

        // Five busy cycles with a branch on the third: five FREEZE cycles, REDIRECT, RUN
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("fz_c0_state", 32'(st), 32'(S_RUN));
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("fz_c1_state", 32'(st), 32'(S_FREEZE));
        checkOutput("fz_c1_ctrl", 32'(ctrl), 32'(C_FREEZE));
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("fz_c2_ctrl", 32'(ctrl), 32'(C_FREEZE));
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("fz_c3_state", 32'(st), 32'(S_FREEZE));
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("fz_c4_state", 32'(st), 32'(S_FREEZE));
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("fz_c5_state", 32'(st), 32'(S_FREEZE));
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("redir_state", 32'(st), 32'(S_REDIR));
        checkOutput("redir_ctrl", 32'(ctrl), 32'(C_FLUSH));
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("post_redir_state", 32'(st), 32'(S_RUN));
        checkOutput("post_redir_ctrl", 32'(ctrl), 32'(C_IDLE));

        // Timeout on the MEM_TIMEOUT=4 instance, starting from a clean reset
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        #3;
        checkOutput("tmo_reset_state", 32'(t_st), 32'(S_RUN));
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("tmo_c0_state", 32'(t_st), 32'(S_RUN));
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1);
            checkOutput($sformatf("tmo_c%0d_state", i), 32'(t_st), 32'(S_FREEZE));
        end
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("tmo_err_state", 32'(t_st), 32'(S_ERR));
        checkOutput("tmo_err_flag", 32'(t_merr), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("tmo_hold_state", 32'(t_st), 32'(S_ERR));
        checkOutput("tmo_hold_flag", 32'(t_merr), 32'd1);
        checkOutput("tmo_hold_ctrl", 32'(t_ctrl), 32'(C_FREEZE));
        checkOutput("no_tmo_state", 32'(st), 32'(S_FREEZE));
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("no_tmo_run_state", 32'(st), 32'(S_RUN));

        // Reset mid-FREEZE with a pending branch, between clock edges
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("pre_rst_state", 32'(st), 32'(S_FREEZE));
        rst = 1'b1;
        #1;
        checkOutput("async_rst_state", 32'(st), 32'(S_RUN));
        checkOutput("async_rst_ctrl", 32'(ctrl), 32'(C_RESET));
        checkOutput("async_rst_mem_err", 32'(t_merr), 32'd0);
        checkOutput("async_rst_tmo_state", 32'(t_st), 32'(S_RUN));
        @(posedge clk);
        #1;
        rst = 1'b0;
        mem_busy = 1'b0;
        #3;
        checkOutput("post_rst_ctrl", 32'(ctrl), 32'(C_IDLE));
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("pending_lost_state", 32'(st), 32'(S_RUN));
        checkOutput("pending_lost_ctrl", 32'(ctrl), 32'(C_IDLE));

`ifdef PIPE_CTRL_PERF_EN
        // Three bubbles and two flushes from a clean reset
        @(posedge clk);
        #1 rst = 1'b1;
        #3;
        checkOutput("perf_reset_stall", stall_cnt, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        #3;
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("perf_stall", stall_cnt, 32'd3);
        checkOutput("perf_flush", flush_cnt, 32'd2);
        checkOutput("perf_freeze", freeze_cnt, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
